// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// Requester count, state encodings and the rotating winner search.
package decoder_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // first set request after last, wrapping back to last itself
  function automatic logic [IDXW-1:0] rr_pick(
    input logic [IDXW-1:0] last,
    input logic [NREQ-1:0] req
  );
    logic [IDXW-1:0] c;
    rr_pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      c = last + IDXW'(k);
      if (req[c]) rr_pick = c;
    end
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_gnt_decoder.sv
// 2-to-4 one-hot grant decoder, all-zero when not enabled.
// Purely combinational; output assigned on every path.
module decoder_rr_arbiter_gnt_decoder
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (idx)
        2'd0:    gnt = 4'b0001;
        2'd1:    gnt = 4'b0010;
        2'd2:    gnt = 4'b0100;
        default: gnt = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter with IDLE/GRANT FSM and one-hot grant.
// Define ARB_TIMEOUT_EN to add the hold-time limit and Timeout pulse.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            En,
  input  logic [NREQ-1:0] Req,
  input  logic            Done,
  output logic [NREQ-1:0] Gnt,
  output logic [IDXW-1:0] Gnt_idx,
  output logic            Busy,
  output logic            Timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_chk
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx_q, idx_nxt;
  logic [IDXW-1:0] last_q, last_nxt;
  logic [IDXW-1:0] win;

  assign win = rr_pick(last_q, Req);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] timer_q;
  logic       hit;
  logic       to_q, to_nxt;

  assign hit = (timer_q == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
`ifdef ARB_TIMEOUT_EN
    to_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (En && |Req) begin
          state_nxt = GRANT;
          idx_nxt   = win;
          last_nxt  = win;
        end
      end
      GRANT: begin
        if (Done || !Req[idx_q]) state_nxt = IDLE;
`ifdef ARB_TIMEOUT_EN
        else if (hit) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= IDLE;
      idx_q  <= '0;
      last_q <= IDXW'(NREQ - 1);
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      last_q <= last_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // timer holds the number of completed GRANT cycles of this owner
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      timer_q <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= to_nxt;
      if (state == GRANT && state_nxt == GRANT)
        timer_q <= timer_q + 8'd1;
      else
        timer_q <= '0;
    end
  end

  assign Timeout = to_q;
`else
  assign Timeout = 1'b0;
`endif

  assign Busy    = (state == GRANT);
  assign Gnt_idx = idx_q;

  decoder_rr_arbiter_gnt_decoder gnt_decoder (
    .idx (idx_q),
    .en  (Busy),
    .gnt (Gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed and randomized bench for decoder_rr_arbiter.
// Reference model tracks owner/last/hold count as plain integers.
module tb_decoder_rr_arbiter;

  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk;
  logic       Rst_n;
  logic       En;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Gnt;
  logic [1:0] Gnt_idx;
  logic       Busy;
  logic       Timeout;

  int tests;
  int failed;

  int m_busy;
  int m_idx;
  int m_last;
  int m_cnt;
  int m_to;

  decoder_rr_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .En      (En),
    .Req     (Req),
    .Done    (Done),
    .Gnt     (Gnt),
    .Gnt_idx (Gnt_idx),
    .Busy    (Busy),
    .Timeout (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic en,
                       input logic [3:0] rq, input logic dn);
    int w;
    int c;
    bit found;
    if (!rn) begin
      m_busy = 0; m_idx = 0; m_last = 3; m_cnt = 0; m_to = 0;
    end else if (m_busy == 0) begin
      m_to = 0;
      if (en && rq != 4'b0000) begin
        found = 1'b0;
        w = m_last;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!found && rq[c]) begin
            w = c;
            found = 1'b1;
          end
        end
        m_idx = w; m_last = w; m_busy = 1; m_cnt = 1;
      end
    end else begin
      m_to = 0;
      if (dn || !rq[m_idx]) m_busy = 0;
      else if (TO_EN && m_cnt == TO) begin
        m_busy = 0;
        m_to = 1;
      end else m_cnt++;
    end
  endtask

  task automatic cycle(input logic rn, input logic en,
                       input logic [3:0] rq, input logic dn);
    logic [3:0] eg;
    Rst_n = rn; En = en; Req = rq; Done = dn;
    @(posedge Clk);
    model(rn, en, rq, dn);
    #1;
    eg = (m_busy != 0) ? (4'b0001 << m_idx) : 4'b0000;
    chk("gnt", Gnt, eg);
    chk("gnt_idx", {2'b00, Gnt_idx}, 4'(m_idx));
    chk("busy", {3'b000, Busy}, 4'(m_busy));
    chk("timeout", {3'b000, Timeout}, 4'(m_to));
  endtask

  initial begin
    tests = 0;
    failed = 0;
    Rst_n = 1'b0; En = 1'b0; Req = '0; Done = 1'b0;

    // reset with all requests asserted
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    chk("rst_gnt", Gnt, 4'b0000);
    chk("rst_busy", {3'b000, Busy}, 4'b0000);
    chk("rst_idx", {2'b00, Gnt_idx}, 4'b0000);
    cycle(1'b1, 1'b1, 4'hF, 1'b0);
    chk("first_gnt", Gnt, 4'b0001);

    // rotation with a gap cycle between grants
    begin
      logic [3:0] seq [4];
      seq[0] = 4'b0010; seq[1] = 4'b0100;
      seq[2] = 4'b1000; seq[3] = 4'b0001;
      for (int i = 0; i < 4; i++) begin
        cycle(1'b1, 1'b1, 4'hF, 1'b1);
        chk("rot_gap", Gnt, 4'b0000);
        cycle(1'b1, 1'b1, 4'hF, 1'b0);
        chk("rot_gnt", Gnt, seq[i]);
      end
    end

    // no preemption while granted
    cycle(1'b1, 1'b1, 4'hF, 1'b1);
    cycle(1'b1, 1'b1, 4'b0100, 1'b0);
    chk("np_gnt", Gnt, 4'b0100);
    cycle(1'b1, 1'b0, 4'b0101, 1'b0);
    cycle(1'b1, 1'b0, 4'b0101, 1'b0);
    chk("np_hold", Gnt, 4'b0100);
    cycle(1'b1, 1'b1, 4'b0101, 1'b1);
    chk("np_gap", Gnt, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0101, 1'b0);
    chk("np_next", Gnt, 4'b0001);

    // owner drops its request without Done
    cycle(1'b1, 1'b1, 4'b0010, 1'b1);
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    chk("drop_gnt", Gnt, 4'b0010);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    chk("drop_rel", Gnt, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    chk("drop_idle", {3'b000, Busy}, 4'b0000);
    chk("drop_idx", {2'b00, Gnt_idx}, 4'b0001);

    // held request with no Done
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    chk("to_held", Gnt, 4'b0010);
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
`ifdef ARB_TIMEOUT_EN
    chk("to_rev", Gnt, 4'b0000);
    chk("to_pulse", {3'b000, Timeout}, 4'b0001);
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    chk("to_regnt", Gnt, 4'b0010);
    chk("to_clr", {3'b000, Timeout}, 4'b0000);
`else
    chk("to_none", Gnt, 4'b0010);
    chk("to_tied", {3'b000, Timeout}, 4'b0000);
`endif

    // reset in the middle of a grant
    cycle(1'b1, 1'b1, 4'b1000, 1'b1);
    cycle(1'b1, 1'b1, 4'b1000, 1'b0);
    chk("mid_gnt", Gnt, 4'b1000);
    cycle(1'b0, 1'b1, 4'b1000, 1'b0);
    chk("mid_rst", Gnt, 4'b0000);
    chk("mid_to", {3'b000, Timeout}, 4'b0000);
    cycle(1'b1, 1'b1, 4'b1000, 1'b0);
    chk("mid_after", Gnt, 4'b1000);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles one owner holds a grant (range 2..255; used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port Rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port En  input  1  arbitration enable; gates new grants only.
REQ-005 SHALL have port Req  input  4  request per requester, level-sensitive.
REQ-006 SHALL have port Done  input  1  current owner releases its grant.
REQ-007 SHALL have port Gnt  output  4  one-hot grant, or 4'b0000 when no owner.
REQ-008 SHALL have port Gnt_idx  output  2  binary index of current or last owner.
REQ-009 SHALL have port Busy  output  1  high while a grant is held.
REQ-010 SHALL have port Timeout  output  1  one-cycle pulse on forced revoke; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-011 SHALL implement FSM states IDLE and GRANT, registered on Clk.
REQ-012 SHALL move IDLE->GRANT when En=1 and Req!=0, and latch the winner into Gnt_idx.
REQ-013 SHALL pick the winner round-robin: search order Last+1, Last+2, Last+3, Last (mod 4), first set Req bit wins.
REQ-014 SHALL update Last to the winner on the IDLE->GRANT transition only.
REQ-015 SHALL assert Gnt and Busy one cycle after the qualifying request is sampled (latency 1).
REQ-016 SHALL derive Gnt = one-hot decode of Gnt_idx while Busy=1 (00->0001, 01->0010, 10->0100, 11->1000), else 0000; never X or Z.
REQ-017 SHALL move GRANT->IDLE when Done=1 or Req[Gnt_idx]=0; Gnt/Busy fall on the next cycle.
REQ-018 SHALL keep Gnt=0000 for at least one cycle between consecutive grants; a new winner is evaluated in that IDLE cycle.
REQ-019 SHALL ignore En while in GRANT; there is no preemption by En or by other requesters.
REQ-020 SHALL ignore Done while in IDLE.
REQ-021 SHALL keep Gnt_idx unchanged in IDLE (holds last owner).
REQ-022 SHALL guarantee each continuously requesting requester a grant within 4 grant cycles.

Reset
REQ-023 SHALL, when Rst_n=0 at a Clk edge, force state IDLE, Gnt=0000, Gnt_idx=2'b00, Busy=0, Timeout=0, Last=3, timer=0.
REQ-024 SHALL abort a grant in progress on reset mid-GRANT with no Timeout pulse; after release the first priority is requester 0.

Configuration
REQ-025 SHALL, with macro ARB_TIMEOUT_EN defined, count cycles in GRANT and force GRANT->IDLE once the count reaches TIMEOUT_CYCLES, pulsing Timeout for exactly that one cycle.
REQ-026 SHALL make a timeout and a simultaneous Done behave as a normal release (Timeout stays 0).
REQ-027 SHALL, without ARB_TIMEOUT_EN, contain no timer logic and drive Timeout constant 0.

Structure
REQ-028 SHALL take the FSM state encodings (IDLE=1'b0, GRANT=1'b1) and the requester count constant (4) from the shared package/header.
REQ-029 SHALL instantiate one combinational sub-module, gnt_decoder (2-to-4, enable=Busy, fully assigned on all paths, no latch), to produce Gnt.

Verification
REQ-030 SHALL cover the reset case: Rst_n=0 for 2 cycles, Req=1111 -> Gnt=0000, Busy=0; after release, the first grant is Gnt=0001 one cycle later.
REQ-031 SHALL cover rotation: Req=1111 held, Done pulsed each grant -> grant order 0001,0010,0100,1000,0001, with one 0000 cycle between grants.
REQ-032 SHALL cover the no-preemption case: Req=0100, granted; then Req=0101 with En=0 -> Gnt stays 0100; Done=1 with En=1 -> next grant is 0001.
REQ-033 SHALL cover the request-drop case: owner 1 granted, Req[1] dropped without Done -> Gnt=0000 next cycle; Req=0000 -> stays IDLE.
REQ-034 SHALL cover timeout with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: Req=0010 held, no Done -> Timeout pulses one cycle after 4 GRANT cycles, and requester 1 is regranted after the one-cycle gap.
REQ-035 SHALL cover reset mid-grant: Rst_n=0 while Gnt=1000 -> Gnt=0000, Timeout=0 next edge; Req=1000 after release -> Gnt=1000.
